// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_ID_CORE   = 1'b0;
  localparam arb_id_t ARB_ID_LOADER = 1'b1;

  function automatic arb_id_t other_id(input arb_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; a held lock pins the grant to the last winner.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  arb_id_t    last,
  input  logic       lock,
  output logic [1:0] grant,
  output arb_id_t    id,
  output logic       any
);

  always_comb begin
    id  = last;
    any = 1'b0;
    if (lock) begin
      // Lock holder keeps the memory; the other port waits even if valid.
      any = valid[last];
      id  = last;
    end else if (valid == 2'b11) begin
      any = 1'b1;
      id  = other_id(last);
    end else if (valid[1]) begin
      any = 1'b1;
      id  = ARB_ID_LOADER;
    end else if (valid[0]) begin
      any = 1'b1;
      id  = ARB_ID_CORE;
    end
    grant = any ? (2'b01 << id) : 2'b00;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the single-ported data memory.
// Optional feature: define ARB_LOCK_EN to add req0_lock/req1_lock grant locking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // Handshake: a request transfers in the cycle where reqN_valid & reqN_ready are both
  // high; valid and payload must stay stable until then. rspN_valid is a one-cycle pulse.
  input  logic                     req0_valid,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     req1_ready,
`ifdef ARB_LOCK_EN
  input  logic                     req0_lock,
  input  logic                     req1_lock,
`endif
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_rdata,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output arb_state_t               dbg_state
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  arb_state_t               state_q, state_d;
  arb_id_t                  last_q, id_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [CW-1:0]            cnt_q;
  logic [DATA_WIDTH-1:0]    rsp0_q, rsp1_q;

  logic [1:0] pick_grant;
  arb_id_t    pick_id;
  logic       pick_any;
  logic       hold_lock;
  logic       accept;
  logic       last_cycle;
  logic [DATA_WIDTH-1:0] cap_data;

`ifdef ARB_LOCK_EN
  assign hold_lock = last_q ? req1_lock : req0_lock;
`else
  assign hold_lock = 1'b0;
`endif

  rr_pick2 u_pick (
    .valid (pick_valid_vec()),
    .last  (last_q),
    .lock  (hold_lock),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  function automatic logic [1:0] pick_valid_vec();
    return {req1_valid, req0_valid};
  endfunction

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any && !rst) begin
          accept  = 1'b1;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: if (cnt_q == CNT_LAST) state_d = ARB_RESP;
      ARB_RESP:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  assign last_cycle = (state_q == ARB_ACCESS) && (cnt_q == CNT_LAST);
  assign cap_data   = we_q ? '0 : mem_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_ID_LOADER;
      id_q    <= ARB_ID_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rsp0_q  <= '0;
      rsp1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q  <= pick_id;
        id_q    <= pick_id;
        we_q    <= pick_id ? req1_we : req0_we;
        addr_q  <= pick_id ? req1_addr : req0_addr;
        wdata_q <= pick_id ? req1_wdata : req0_wdata;
        cnt_q   <= '0;
      end else if (state_q == ARB_ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Each port keeps its own last response value until its next response.
      if (last_cycle) begin
        if (id_q == ARB_ID_LOADER) rsp1_q <= cap_data;
        else                       rsp0_q <= cap_data;
      end
    end
  end

  assign req0_ready = accept & pick_grant[0];
  assign req1_ready = accept & pick_grant[1];
  assign rsp0_valid = (state_q == ARB_RESP) && (id_q == ARB_ID_CORE);
  assign rsp1_valid = (state_q == ARB_RESP) && (id_q == ARB_ID_LOADER);
  assign rsp0_rdata = rsp0_q;
  assign rsp1_rdata = rsp1_q;

  // Single write edge: only the first ACCESS cycle may raise mem_we.
  assign mem_we    = (state_q == ARB_ACCESS) && (cnt_q == '0) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wd    = wdata_q;
  assign dbg_state = state_q;

endmodule
